mem_store_buffer: RTL and testbench
===================================

# mem_store_buffer

Memory-stage store path: the write-side counterpart of the write-back load extractor. It takes committed stores (SB/SH/SW/SWL/SWR) with the raw rt value and byte address, and produces word-aligned write data and byte strobes. Stores queue in a small FIFO, with same-word merging into the youngest entry, and drain to the data cache over a valid/ready handshake. It also provides combinational store-to-load forwarding so younger loads see buffered bytes.

## Interface
- DEPTH, 4, number of buffer entries; power of two, ≥2
- clk  in  1  clock; all state updates on rising edge
- resetn  in  1  synchronous, active-low reset
- st_valid  in  1  committed store request
- st_ready  out  1  buffer can accept; equals !sb_full
- st_addr  in  32  byte address
- st_data  in  32  raw rt register value
- st_type  in  StoreType  {size[1:0], LeftOrRight[1:0]}
- st_ades  out  1  address-error-on-store; combinational, valid when st_valid
- dc_req  out  1  head entry valid toward data cache
- dc_ready  in  1  cache accepts head this cycle
- dc_addr  out  32  {head.addr[31:2], 2'b00}
- dc_wstrb  out  4  head byte strobes
- dc_wdata  out  32  head aligned data
- ld_addr  in  32  load byte address for forwarding lookup
- ld_hit_strb  out  4  bytes of ld_addr's word present in buffer
- ld_hit_data  out  32  forwarded bytes (lanes with strb=0 are don't-care)
- sb_empty  out  1  no valid entries
- sb_full  out  1  count == DEPTH

## Operation
- Alignment (little-endian, a = st_addr[1:0]):
  - SB: strb = 1<<a; data = {4{rt[7:0]}}.
  - SH: strb = a[1] ? 1100 : 0011; data = {2{rt[15:0]}}.
  - SW: strb = 1111; data = rt.
  - SWL, by a = 00/01/10/11: strb 0001/0011/0111/1111; data {24'b0,rt[31:24]}, {16'b0,rt[31:16]}, {8'b0,rt[31:8]}, rt.
  - SWR, by a = 00/01/10/11: strb 1111/1110/1100/1000; data rt, {rt[23:0],8'b0}, {rt[15:0],16'b0}, {rt[7:0],24'b0}.
- st_ades = st_valid & ((SH & a[0]) | (SW & a≠00)). The faulting store is consumed when st_ready is high but never written. SWL/SWR never fault.
- Push happens when st_valid & st_ready & !st_ades.
  - Merge: if count ≥ 2 and the tail entry's addr[31:2] equals the incoming one, the incoming store merges into the tail. Strobes are ORed; incoming bytes overwrite per set strobe. Count is unchanged.
  - Otherwise the store is written to a new tail entry.
  - A store never merges into the head, because the head may be in flight.
- Pop happens on dc_req & dc_ready. The head pointer advances.
- Forwarding: ld_addr[31:2] is compared against all valid entries. For each byte lane, the youngest matching entry with that strobe set supplies the byte. The store being pushed in the same cycle is not visible.
- Pointers wrap modulo DEPTH. Count uses log2(DEPTH)+1 bits.

## Timing
- Reset values: all entries invalid, pointers 0, count 0, dc_req 0, sb_empty 1, sb_full 0, ld_hit_strb 0.
- A pushed store is visible on dc_* and the forwarding outputs the cycle after acceptance. Minimum latency from st_valid to dc_req is 1 cycle.
- dc_addr, dc_wstrb and dc_wdata are held stable while dc_req is high and dc_ready is low.
- Push and pop in the same cycle: count unchanged. When full, a simultaneous pop does not raise st_ready in that cycle; st_ready has no combinational dependence on dc_ready.
- Merge with a simultaneous pop (count == 2) is legal. The merged tail becomes the head next cycle with the merged contents.
- Reset while dc_req is high drops all entries on the next edge. No further requests are issued.

## Structure
- Shared package holds:
  - StoreType struct;
  - STORETYPE_SB/SH/SW/SWL/SWR constants, using the same {size, LeftOrRight} encoding as LoadType;
  - SBEntry struct {addr[31:2], strb[3:0], data[31:0]}.
- Sub-module store_align: purely combinational. Takes (st_type, a, rt) and produces (strb, data, ades); mem_store_buffer instantiates it.

## Test plan
- SB to 0x1000_0003 with rt=0x1234_5678, then dc_ready=1 -> next cycle dc_req=1, dc_addr=0x1000_0000, dc_wstrb=1000, dc_wdata=0x7878_7878; popped after one handshake, sb_empty=1.
- SWL/SWR sweep with rt=0xAABB_CCDD for a=00..11 -> SWL a=01 gives strb=0011, data=0x0000_AABB; SWR a=10 gives strb=1100, data=0xCCDD_0000; all eight match the Operation rules.
- SH to 0x...01 and SW to 0x...02 -> st_ades=1 in that cycle, count unchanged, nothing issued.
- dc_ready=0, store SW to 0x100, then SB 0x55 to 0x204, then SB 0x66 to 0x205 -> count=2 (third merged); tail strb=0011, data[15:0]=0x6655; ld_addr=0x205 gives ld_hit_strb=0011.
- Fill DEPTH=4 with dc_ready=0 -> sb_full=1, st_ready=0. Raise dc_ready for one cycle -> st_ready high the following cycle; pointers wrap with order preserved.
- Assert resetn=0 mid-drain with count=3 -> next cycle dc_req=0, sb_empty=1, ld_hit_strb=0.

Source files
------------

// File: rtl/mem_store_buffer_pkg.sv
// Shared types for the memory-stage store path: store-type encoding and buffer entry layout.
// The {size, left_or_right} encoding matches the load-type encoding of the write-back extractor.
package mem_store_buffer_pkg;

  typedef struct packed {
    logic [1:0] size;          // 00 byte, 01 half, 10 word
    logic [1:0] left_or_right; // 00 plain, 01 left, 10 right
  } StoreType;

  localparam StoreType STORETYPE_SB  = '{size: 2'b00, left_or_right: 2'b00};
  localparam StoreType STORETYPE_SH  = '{size: 2'b01, left_or_right: 2'b00};
  localparam StoreType STORETYPE_SW  = '{size: 2'b10, left_or_right: 2'b00};
  localparam StoreType STORETYPE_SWL = '{size: 2'b10, left_or_right: 2'b01};
  localparam StoreType STORETYPE_SWR = '{size: 2'b10, left_or_right: 2'b10};

  typedef struct packed {
    logic [29:0] addr;
    logic [3:0]  strb;
    logic [31:0] data;
  } SBEntry;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_data,
                                              input logic [31:0] new_data,
                                              input logic [3:0]  new_strb);
    logic [31:0] res;
    res = old_data;
    for (int b = 0; b < 4; b++) begin
      if (new_strb[b]) res[8*b +: 8] = new_data[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/store_align.sv
// Combinational store alignment: turns (type, low address bits, rt) into lane strobes,
// lane-replicated write data and the misaligned-address fault flag.
module store_align
  import mem_store_buffer_pkg::*;
(
  input  StoreType    st_type,
  input  logic [1:0]  a,
  input  logic [31:0] rt,
  output logic [3:0]  strb,
  output logic [31:0] data,
  output logic        ades
);

  always_comb begin
    strb = 4'b0000;
    data = 32'h0;
    ades = 1'b0;
    case (st_type)
      STORETYPE_SB: begin
        strb = 4'b0001 << a;
        data = {4{rt[7:0]}};
      end
      STORETYPE_SH: begin
        strb = a[1] ? 4'b1100 : 4'b0011;
        data = {2{rt[15:0]}};
        ades = a[0];
      end
      STORETYPE_SW: begin
        strb = 4'b1111;
        data = rt;
        ades = (a != 2'b00);
      end
      // Unaligned left/right pairs: the left half covers the low lanes up to a.
      STORETYPE_SWL: begin
        case (a)
          2'b00:   begin strb = 4'b0001; data = {24'h0, rt[31:24]}; end
          2'b01:   begin strb = 4'b0011; data = {16'h0, rt[31:16]}; end
          2'b10:   begin strb = 4'b0111; data = {8'h0,  rt[31:8]};  end
          default: begin strb = 4'b1111; data = rt;                 end
        endcase
      end
      STORETYPE_SWR: begin
        case (a)
          2'b00:   begin strb = 4'b1111; data = rt;                 end
          2'b01:   begin strb = 4'b1110; data = {rt[23:0], 8'h0};   end
          2'b10:   begin strb = 4'b1100; data = {rt[15:0], 16'h0};  end
          default: begin strb = 4'b1000; data = {rt[7:0],  24'h0};  end
        endcase
      end
      default: begin
        strb = 4'b0000;
        data = 32'h0;
        ades = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mem_store_buffer.sv
// Store buffer: queues aligned committed stores, merges same-word stores into the youngest
// non-head entry, drains to the data cache over valid/ready, and forwards bytes to loads.
module mem_store_buffer
  import mem_store_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  StoreType    st_type,
  output logic        st_ades,
  output logic        dc_req,
  input  logic        dc_ready,
  output logic [31:0] dc_addr,
  output logic [3:0]  dc_wstrb,
  output logic [31:0] dc_wdata,
  input  logic [31:0] ld_addr,
  output logic [3:0]  ld_hit_strb,
  output logic [31:0] ld_hit_data,
  output logic        sb_empty,
  output logic        sb_full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]    head_ptr;
  logic [PW-1:0]    tail_ptr;
  logic [PW-1:0]    last_ptr;
  logic [CW-1:0]    count;
  logic [DEPTH-1:0] ent_vld;
  SBEntry           entries [DEPTH];

  logic [3:0]  al_strb;
  logic [31:0] al_data;
  logic        al_ades;
  logic        push;
  logic        merge;
  logic        alloc;
  logic        pop;
  logic        ld_addr_unused;

  store_align u_align (
    .st_type (st_type),
    .a       (st_addr[1:0]),
    .rt      (st_data),
    .strb    (al_strb),
    .data    (al_data),
    .ades    (al_ades)
  );

  assign ld_addr_unused = ^ld_addr[1:0];

  assign sb_empty = (count == '0);
  assign sb_full  = (count == CW'(DEPTH));
  assign st_ready = ~sb_full;
  assign st_ades  = st_valid & al_ades;

  assign last_ptr = tail_ptr - PW'(1);
  assign push     = st_valid & st_ready & ~al_ades;
  // count >= 2 guarantees the tail is not the head, which may already be in flight.
  assign merge    = push & (count >= CW'(2)) & (entries[last_ptr].addr == st_addr[31:2]);
  assign alloc    = push & ~merge;

  assign dc_req   = ~sb_empty;
  assign pop      = dc_req & dc_ready;
  assign dc_addr  = {entries[head_ptr].addr, 2'b00};
  assign dc_wstrb = entries[head_ptr].strb;
  assign dc_wdata = entries[head_ptr].data;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
      ent_vld  <= '0;
    end else begin
      if (pop) begin
        ent_vld[head_ptr] <= 1'b0;
        head_ptr          <= head_ptr + PW'(1);
      end
      if (alloc) begin
        ent_vld[tail_ptr] <= 1'b1;
        tail_ptr          <= tail_ptr + PW'(1);
      end
      case ({alloc, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry payload carries no reset; validity is tracked by ent_vld and count.
  always_ff @(posedge clk) begin
    if (alloc) begin
      entries[tail_ptr] <= '{addr: st_addr[31:2], strb: al_strb, data: al_data};
    end else if (merge) begin
      entries[last_ptr] <= '{addr: entries[last_ptr].addr,
                             strb: entries[last_ptr].strb | al_strb,
                             data: merge_bytes(entries[last_ptr].data, al_data, al_strb)};
    end
  end

  // Walk oldest to youngest so the youngest matching entry wins each lane.
  always_comb begin
    logic [PW-1:0] idx;
    idx         = '0;
    ld_hit_strb = 4'b0000;
    ld_hit_data = 32'h0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_ptr + PW'(i);
      if (ent_vld[idx] && (entries[idx].addr == ld_addr[31:2])) begin
        for (int b = 0; b < 4; b++) begin
          if (entries[idx].strb[b]) begin
            ld_hit_strb[b]        = 1'b1;
            ld_hit_data[8*b +: 8] = entries[idx].data[8*b +: 8];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_store_buffer.sv
// Directed bench for mem_store_buffer: alignment vector table plus hand-written
// sequences for merging, fill/wrap, merge-with-pop and reset during drain.
module tb_mem_store_buffer;
  import mem_store_buffer_pkg::*;

  logic        clk;
  logic        resetn;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  StoreType    st_type;
  logic        st_ades;
  logic        dc_req;
  logic        dc_ready;
  logic [31:0] dc_addr;
  logic [3:0]  dc_wstrb;
  logic [31:0] dc_wdata;
  logic [31:0] ld_addr;
  logic [3:0]  ld_hit_strb;
  logic [31:0] ld_hit_data;
  logic        sb_empty;
  logic        sb_full;

  int n_cmp;
  int n_err;

  mem_store_buffer #(.DEPTH(4)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .st_valid    (st_valid),
    .st_ready    (st_ready),
    .st_addr     (st_addr),
    .st_data     (st_data),
    .st_type     (st_type),
    .st_ades     (st_ades),
    .dc_req      (dc_req),
    .dc_ready    (dc_ready),
    .dc_addr     (dc_addr),
    .dc_wstrb    (dc_wstrb),
    .dc_wdata    (dc_wdata),
    .ld_addr     (ld_addr),
    .ld_hit_strb (ld_hit_strb),
    .ld_hit_data (ld_hit_data),
    .sb_empty    (sb_empty),
    .sb_full     (sb_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "bench did not terminate");
  end

  typedef struct {
    StoreType    typ;
    logic [31:0] addr;
    logic [31:0] rt;
    logic        ades;
    logic [3:0]  strb;
    logic [31:0] data;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_st(input StoreType t, input logic [31:0] a, input logic [31:0] d);
    st_valid = 1'b1;
    st_type  = t;
    st_addr  = a;
    st_data  = d;
  endtask

  function automatic logic [31:0] lane_mask(input logic [3:0] s);
    return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
  endfunction

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    resetn   = 1'b0;
    st_valid = 1'b0;
    st_addr  = 32'h0;
    st_data  = 32'h0;
    st_type  = STORETYPE_SB;
    dc_ready = 1'b0;
    ld_addr  = 32'h0;

    vecs[0]  = '{STORETYPE_SB,  32'h1000_0003, 32'h1234_5678, 1'b0, 4'b1000, 32'h7878_7878};
    vecs[1]  = '{STORETYPE_SWL, 32'h0000_0020, 32'hAABB_CCDD, 1'b0, 4'b0001, 32'h0000_00AA};
    vecs[2]  = '{STORETYPE_SWL, 32'h0000_0021, 32'hAABB_CCDD, 1'b0, 4'b0011, 32'h0000_AABB};
    vecs[3]  = '{STORETYPE_SWL, 32'h0000_0022, 32'hAABB_CCDD, 1'b0, 4'b0111, 32'h00AA_BBCC};
    vecs[4]  = '{STORETYPE_SWL, 32'h0000_0023, 32'hAABB_CCDD, 1'b0, 4'b1111, 32'hAABB_CCDD};
    vecs[5]  = '{STORETYPE_SWR, 32'h0000_0020, 32'hAABB_CCDD, 1'b0, 4'b1111, 32'hAABB_CCDD};
    vecs[6]  = '{STORETYPE_SWR, 32'h0000_0021, 32'hAABB_CCDD, 1'b0, 4'b1110, 32'hBBCC_DD00};
    vecs[7]  = '{STORETYPE_SWR, 32'h0000_0022, 32'hAABB_CCDD, 1'b0, 4'b1100, 32'hCCDD_0000};
    vecs[8]  = '{STORETYPE_SWR, 32'h0000_0023, 32'hAABB_CCDD, 1'b0, 4'b1000, 32'hDD00_0000};
    vecs[9]  = '{STORETYPE_SH,  32'h0000_0032, 32'hAABB_CCDD, 1'b0, 4'b1100, 32'hCCDD_CCDD};
    vecs[10] = '{STORETYPE_SH,  32'h0000_0030, 32'hAABB_CCDD, 1'b0, 4'b0011, 32'hCCDD_CCDD};
    vecs[11] = '{STORETYPE_SW,  32'h0000_0040, 32'hAABB_CCDD, 1'b0, 4'b1111, 32'hAABB_CCDD};
    vecs[12] = '{STORETYPE_SH,  32'h0000_0031, 32'hAABB_CCDD, 1'b1, 4'b0000, 32'h0000_0000};
    vecs[13] = '{STORETYPE_SW,  32'h0000_0042, 32'hAABB_CCDD, 1'b1, 4'b0000, 32'h0000_0000};
    vecs[14] = '{STORETYPE_SB,  32'h0000_0041, 32'hAABB_CCDD, 1'b0, 4'b0010, 32'hDDDD_DDDD};

    // Reset state
    step();
    step();
    chk("rst_dc_req", {31'h0, dc_req}, 32'h0);
    chk("rst_empty", {31'h0, sb_empty}, 32'h1);
    chk("rst_full", {31'h0, sb_full}, 32'h0);
    chk("rst_st_ready", {31'h0, st_ready}, 32'h1);
    chk("rst_ld_hit_strb", {28'h0, ld_hit_strb}, 32'h0);
    resetn = 1'b1;
    step();

    // Alignment and fault table
    for (int k = 0; k < 15; k++) begin
      drive_st(vecs[k].typ, vecs[k].addr, vecs[k].rt);
      ld_addr  = vecs[k].addr;
      dc_ready = 1'b0;
      #1;
      chk($sformatf("v%0d_ades", k), {31'h0, st_ades}, {31'h0, vecs[k].ades});
      step();
      st_valid = 1'b0;
      if (vecs[k].ades) begin
        chk($sformatf("v%0d_empty", k), {31'h0, sb_empty}, 32'h1);
        chk($sformatf("v%0d_dc_req", k), {31'h0, dc_req}, 32'h0);
      end else begin
        chk($sformatf("v%0d_dc_req", k), {31'h0, dc_req}, 32'h1);
        chk($sformatf("v%0d_dc_addr", k), dc_addr, {vecs[k].addr[31:2], 2'b00});
        chk($sformatf("v%0d_wstrb", k), {28'h0, dc_wstrb}, {28'h0, vecs[k].strb});
        chk($sformatf("v%0d_wdata", k), dc_wdata, vecs[k].data);
        chk($sformatf("v%0d_fwd_strb", k), {28'h0, ld_hit_strb}, {28'h0, vecs[k].strb});
        chk($sformatf("v%0d_fwd_data", k), ld_hit_data & lane_mask(vecs[k].strb),
            vecs[k].data & lane_mask(vecs[k].strb));
      end
      dc_ready = 1'b1;
      step();
      dc_ready = 1'b0;
      chk($sformatf("v%0d_drained", k), {31'h0, sb_empty}, 32'h1);
    end

    // Merge into youngest entry while the head is stalled
    drive_st(STORETYPE_SW, 32'h0000_0100, 32'h1122_3344);
    step();
    drive_st(STORETYPE_SB, 32'h0000_0204, 32'h0000_0055);
    step();
    drive_st(STORETYPE_SB, 32'h0000_0205, 32'h0000_0066);
    step();
    st_valid = 1'b0;
    ld_addr  = 32'h0000_0205;
    #1;
    chk("mrg_head_addr_held", dc_addr, 32'h0000_0100);
    chk("mrg_head_wstrb", {28'h0, dc_wstrb}, 32'hF);
    chk("mrg_fwd_strb", {28'h0, ld_hit_strb}, 32'h3);
    chk("mrg_fwd_data", ld_hit_data & 32'h0000_FFFF, 32'h0000_6655);
    ld_addr = 32'h0000_0100;
    #1;
    chk("mrg_fwd_head_data", ld_hit_data, 32'h1122_3344);
    dc_ready = 1'b1;
    step();
    chk("mrg_tail_addr", dc_addr, 32'h0000_0204);
    chk("mrg_tail_wstrb", {28'h0, dc_wstrb}, 32'h3);
    chk("mrg_tail_wdata", dc_wdata & 32'h0000_FFFF, 32'h0000_6655);
    step();
    dc_ready = 1'b0;
    chk("mrg_count2_empty", {31'h0, sb_empty}, 32'h1);

    // Same word with only one entry: must not merge into the head
    drive_st(STORETYPE_SB, 32'h0000_0300, 32'h0000_0077);
    step();
    drive_st(STORETYPE_SB, 32'h0000_0301, 32'h0000_0088);
    step();
    st_valid = 1'b0;
    chk("nomrg_head_wstrb", {28'h0, dc_wstrb}, 32'h1);
    dc_ready = 1'b1;
    step();
    chk("nomrg_second_req", {31'h0, dc_req}, 32'h1);
    chk("nomrg_second_wstrb", {28'h0, dc_wstrb}, 32'h2);
    step();
    dc_ready = 1'b0;
    chk("nomrg_empty", {31'h0, sb_empty}, 32'h1);

    // Merge with simultaneous pop at count == 2
    drive_st(STORETYPE_SB, 32'h0000_0600, 32'h0000_0011);
    step();
    drive_st(STORETYPE_SB, 32'h0000_0604, 32'h0000_0022);
    step();
    drive_st(STORETYPE_SB, 32'h0000_0605, 32'h0000_0033);
    dc_ready = 1'b1;
    step();
    st_valid = 1'b0;
    dc_ready = 1'b0;
    chk("mpop_head_addr", dc_addr, 32'h0000_0604);
    chk("mpop_head_wstrb", {28'h0, dc_wstrb}, 32'h3);
    chk("mpop_head_wdata", dc_wdata & 32'h0000_FFFF, 32'h0000_3322);
    dc_ready = 1'b1;
    step();
    dc_ready = 1'b0;
    chk("mpop_empty", {31'h0, sb_empty}, 32'h1);

    // Fill, full back-pressure, pop without same-cycle ready, wrap
    for (int i = 0; i < 4; i++) begin
      drive_st(STORETYPE_SW, 32'h0000_0400 + 32'(4 * i), 32'h0000_00A0 + 32'(i));
      step();
    end
    drive_st(STORETYPE_SW, 32'h0000_0410, 32'h0000_00A4);
    #1;
    chk("fill_full", {31'h0, sb_full}, 32'h1);
    chk("fill_st_ready", {31'h0, st_ready}, 32'h0);
    dc_ready = 1'b1;
    #1;
    chk("fill_ready_no_comb", {31'h0, st_ready}, 32'h0);
    step();
    dc_ready = 1'b0;
    chk("fill_after_pop_full", {31'h0, sb_full}, 32'h0);
    chk("fill_after_pop_ready", {31'h0, st_ready}, 32'h1);
    chk("fill_after_pop_head", dc_addr, 32'h0000_0404);
    ld_addr = 32'h0000_0408;
    #1;
    chk("fill_fwd_strb", {28'h0, ld_hit_strb}, 32'hF);
    chk("fill_fwd_data", ld_hit_data, 32'h0000_00A2);
    step();
    st_valid = 1'b0;
    chk("wrap_full", {31'h0, sb_full}, 32'h1);
    dc_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      chk($sformatf("wrap_addr%0d", j), dc_addr, 32'h0000_0404 + 32'(4 * j));
      chk($sformatf("wrap_data%0d", j), dc_wdata, 32'h0000_00A1 + 32'(j));
      step();
    end
    dc_ready = 1'b0;
    chk("wrap_empty", {31'h0, sb_empty}, 32'h1);

    // Youngest-wins forwarding, then reset in the middle of a drain
    drive_st(STORETYPE_SB, 32'h0000_0500, 32'h0000_0011);
    step();
    drive_st(STORETYPE_SW, 32'h0000_0504, 32'hCAFE_BABE);
    step();
    drive_st(STORETYPE_SB, 32'h0000_0500, 32'h0000_0022);
    step();
    st_valid = 1'b0;
    ld_addr  = 32'h0000_0500;
    #1;
    chk("young_fwd_strb", {28'h0, ld_hit_strb}, 32'h1);
    chk("young_fwd_data", ld_hit_data & 32'h0000_00FF, 32'h0000_0022);
    dc_ready = 1'b1;
    resetn   = 1'b0;
    step();
    chk("rstd_dc_req", {31'h0, dc_req}, 32'h0);
    chk("rstd_empty", {31'h0, sb_empty}, 32'h1);
    chk("rstd_fwd_strb", {28'h0, ld_hit_strb}, 32'h0);
    resetn   = 1'b1;
    dc_ready = 1'b0;
    step();
    chk("rstd_still_idle", {31'h0, dc_req}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
